// File: rtl/tdc_thermo_encoder.sv
// Synchroniser, bubble filter and binary encoder for a TDC delay-line snapshot.
// Path: capture, metastability flop, 3-tap majority filter, then leading-ones count.
module tdc_thermo_encoder #(
  parameter int N      = 64,
  parameter int CODE_W = $clog2(N) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      meas_i,
  input  logic              sample_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  output logic              overflow_o,
  output logic              zero_o,
  output logic              bubble_o
);

  // Handshake: valid-only stream with no ready. Each cycle sample_i is high
  // yields exactly one valid_o pulse; code_o and the flags change only with it.
  logic [N-1:0]      cap1, cap2, corr_q, corr_d;
  logic [N+1:0]      ext;
  logic              v1, v2, v3, bub_q, bub_d;
  logic [CODE_W-1:0] code_d;

  // Padding: a virtual 1 below tap 0 and a virtual 0 above the last tap.
  assign ext = {1'b0, cap2, 1'b1};

  always_comb begin
    corr_d = '0;
    for (int i = 0; i < N; i++) begin
      corr_d[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
    // x & (x+1) clears the low run of ones; anything left over is a bubble.
    bub_d = |(cap2 & (cap2 + N'(1)));
  end

  always_comb begin
    code_d = CODE_W'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (!corr_q[i]) code_d = CODE_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap1       <= '0;
      cap2       <= '0;
      corr_q     <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      bub_q      <= 1'b0;
      code_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      zero_o     <= 1'b0;
      bubble_o   <= 1'b0;
    end else begin
      if (sample_i) begin
        cap1 <= meas_i;
        v1   <= 1'b1;
      end else begin
        v1   <= 1'b0;
      end
      cap2    <= cap1;
      v2      <= v1;
      corr_q  <= corr_d;
      bub_q   <= bub_d;
      v3      <= v2;
      valid_o <= v3;
      if (v3) begin
        code_o     <= code_d;
        overflow_o <= (code_d == CODE_W'(N));
        zero_o     <= (code_d == '0);
        bubble_o   <= bub_q;
      end
    end
  end

endmodule
